// File: rtl/detonator_seq_ctrl_if.sv
// Key/status bundle between the debounced keypad front end and the
// detonator sequencing controller. The master side drives the key pulses
// and the digit bus; the slave side (the controller) drives state and lamps.
interface detonator_seq_ctrl_if;
    logic       setup_p;
    logic       ready_p;
    logic       fire_p;
    logic       sure_p;
    logic       confirm_p;
    logic       wait_p;
    logic [3:0] digit;
    logic [2:0] state;
    logic [2:0] digit_cnt;
    logic [3:0] last_digit;
    logic [2:0] tries_left;
    logic       lt;
    logic       bt;
    logic       rt;
    logic       fired;
    logic       err;

    modport master (
        output setup_p, ready_p, fire_p, sure_p, confirm_p, wait_p, digit,
        input  state, digit_cnt, last_digit, tries_left, lt, bt, rt, fired, err
    );

    modport slave (
        input  setup_p, ready_p, fire_p, sure_p, confirm_p, wait_p, digit,
        output state, digit_cnt, last_digit, tries_left, lt, bt, rt, fired, err
    );
endinterface

// File: rtl/detonator_seq_ctrl.sv
// Sequencing controller for the numeric code detonator: stores a code in
// SET, arms, collects and compares the firing code, counts wrong attempts
// and enforces a timed lockout. All outputs are registered.
// Optional feature: define DETONATOR_ENTRY_TIMEOUT_EN to give up on code
// entry after TIMEOUT_CYC idle cycles (counted as a wrong attempt).
module detonator_seq_ctrl #(
    parameter int CODE_LEN    = 4,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000,
    parameter int LOCK_CYC    = 5000
) (
    input logic clk,
    input logic rst,
    detonator_seq_ctrl_if.slave bus
);
    localparam int TMAX = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [2:0] CL = 3'(CODE_LEN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_ARMED = 3'd2,
        S_ENTRY = 3'd3,
        S_CHECK = 3'd4,
        S_FIRED = 3'd5,
        S_LOCK  = 3'd6
    } state_t;

    state_t                     r_state, w_stateNext;
    logic [2:0]                 r_digitCnt, w_digitCntNext;
    logic [3:0]                 r_lastDigit, w_lastDigitNext;
    logic [2:0]                 r_triesLeft, w_triesLeftNext;
    logic                       r_fired, w_firedNext;
    logic                       r_err, w_errNext;
    logic                       r_lt, r_bt, r_rt;
    logic [CODE_LEN-1:0][3:0]   r_code, w_codeNext;
    logic [CODE_LEN-1:0][3:0]   r_entry, w_entryNext;
    logic [TW-1:0]              r_timer, w_timerNext;
    logic                       r_forceMis, w_forceMisNext;

    logic w_wait, w_cmd, w_setup, w_ready, w_fire, w_sure, w_confirm;
    logic w_digitOk, w_bufFull, w_codeMatch;

    // Resolve same-cycle pulses: wait beats commands, commands beat confirm.
    assign w_wait      = bus.wait_p;
    assign w_cmd       = bus.setup_p | bus.ready_p | bus.fire_p | bus.sure_p;
    assign w_setup     = bus.setup_p & ~w_wait;
    assign w_ready     = bus.ready_p & ~w_wait;
    assign w_fire      = bus.fire_p  & ~w_wait;
    assign w_sure      = bus.sure_p  & ~w_wait;
    assign w_confirm   = bus.confirm_p & ~w_wait & ~w_cmd;
    assign w_digitOk   = (bus.digit <= 4'd9);
    assign w_bufFull   = (r_digitCnt == CL);
    assign w_codeMatch = (r_code == r_entry);

    // Next-state and datapath decisions for every state.
    always_comb begin
        w_stateNext     = r_state;
        w_digitCntNext  = r_digitCnt;
        w_lastDigitNext = r_lastDigit;
        w_triesLeftNext = r_triesLeft;
        w_firedNext     = 1'b0;
        w_errNext       = 1'b0;
        w_codeNext      = r_code;
        w_entryNext     = r_entry;
        w_timerNext     = r_timer;
        w_forceMisNext  = r_forceMis;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_stateNext    = S_SET;
                    w_codeNext     = '0;
                    w_digitCntNext = '0;
                end
            end
            S_SET: begin
                if (w_wait) begin
                    w_stateNext    = S_IDLE;
                    w_codeNext     = '0;
                    w_digitCntNext = '0;
                end else if (w_ready) begin
                    if (w_bufFull) begin
                        w_stateNext     = S_ARMED;
                        w_triesLeftNext = 3'(MAX_TRIES);
                        w_digitCntNext  = '0;
                    end else begin
                        w_errNext = 1'b1;
                    end
                end else if (w_confirm) begin
                    if (w_digitOk && !w_bufFull) begin
                        for (int i = 0; i < CODE_LEN; i++) begin
                            if (3'(i) == r_digitCnt) w_codeNext[i] = bus.digit;
                        end
                        w_digitCntNext  = r_digitCnt + 3'd1;
                        w_lastDigitNext = bus.digit;
                    end else begin
                        w_errNext = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (w_wait) begin
                    w_stateNext    = S_IDLE;
                    w_codeNext     = '0;
                    w_digitCntNext = '0;
                end else if (w_fire) begin
                    w_stateNext    = S_ENTRY;
                    w_entryNext    = '0;
                    w_digitCntNext = '0;
                    w_timerNext    = TW'(TIMEOUT_CYC);
                end
            end
            S_ENTRY: begin
                if (w_wait) begin
                    w_stateNext    = S_ARMED;
                    w_digitCntNext = '0;
                end else if (w_sure && w_bufFull) begin
                    w_stateNext = S_CHECK;
                end else if (w_confirm && w_digitOk && !w_bufFull) begin
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (3'(i) == r_digitCnt) w_entryNext[i] = bus.digit;
                    end
                    w_digitCntNext  = r_digitCnt + 3'd1;
                    w_lastDigitNext = bus.digit;
                    w_timerNext     = TW'(TIMEOUT_CYC);
                end else begin
                    if (w_sure || w_confirm) w_errNext = 1'b1;
`ifdef DETONATOR_ENTRY_TIMEOUT_EN
                    if (r_timer <= TW'(1)) begin
                        w_stateNext    = S_CHECK;
                        w_forceMisNext = 1'b1;
                    end else begin
                        w_timerNext = r_timer - TW'(1);
                    end
`endif
                end
            end
            S_CHECK: begin
                w_forceMisNext = 1'b0;
                if (w_codeMatch && !r_forceMis) begin
                    w_stateNext = S_FIRED;
                    w_firedNext = 1'b1;
                end else begin
                    w_errNext       = 1'b1;
                    w_digitCntNext  = '0;
                    w_triesLeftNext = (r_triesLeft != 3'd0) ? r_triesLeft - 3'd1 : 3'd0;
                    if (r_triesLeft <= 3'd1) begin
                        w_stateNext = S_LOCK;
                        w_timerNext = TW'(LOCK_CYC);
                    end else begin
                        w_stateNext = S_ARMED;
                    end
                end
            end
            S_FIRED: begin
                w_stateNext = S_FIRED;
            end
            S_LOCK: begin
                if (r_timer <= TW'(1)) begin
                    w_stateNext    = S_IDLE;
                    w_codeNext     = '0;
                    w_entryNext    = '0;
                    w_digitCntNext = '0;
                end else begin
                    w_timerNext = r_timer - TW'(1);
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // State and output registers; lamps are decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_digitCnt  <= '0;
            r_lastDigit <= '0;
            r_triesLeft <= '0;
            r_fired     <= 1'b0;
            r_err       <= 1'b0;
            r_lt        <= 1'b1;
            r_bt        <= 1'b0;
            r_rt        <= 1'b0;
            r_code      <= '0;
            r_entry     <= '0;
            r_timer     <= '0;
            r_forceMis  <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_digitCnt  <= w_digitCntNext;
            r_lastDigit <= w_lastDigitNext;
            r_triesLeft <= w_triesLeftNext;
            r_fired     <= w_firedNext;
            r_err       <= w_errNext;
            r_lt        <= (w_stateNext == S_IDLE);
            r_bt        <= (w_stateNext == S_ARMED) || (w_stateNext == S_ENTRY);
            r_rt        <= (w_stateNext == S_FIRED) || (w_stateNext == S_LOCK);
            r_code      <= w_codeNext;
            r_entry     <= w_entryNext;
            r_timer     <= w_timerNext;
            r_forceMis  <= w_forceMisNext;
        end
    end

    assign bus.state      = r_state;
    assign bus.digit_cnt  = r_digitCnt;
    assign bus.last_digit = r_lastDigit;
    assign bus.tries_left = r_triesLeft;
    assign bus.lt         = r_lt;
    assign bus.bt         = r_bt;
    assign bus.rt         = r_rt;
    assign bus.fired      = r_fired;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_detonator_seq_ctrl.sv
// Testbench for detonator_seq_ctrl: a table of directed vectors, hand-written
// lockout/reset/timeout sequences, and a random run against a queue-based
// reference model of the keypad rules.
module tb_detonator_seq_ctrl;
    localparam int CL          = 4;
    localparam int MT          = 3;
    localparam int TIMEOUT_CYC = 10;
    localparam int LOCK_CYC    = 40;
`ifdef DETONATOR_ENTRY_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam logic [5:0] K_NONE = 6'b000000;
    localparam logic [5:0] K_SET  = 6'b100000;
    localparam logic [5:0] K_RDY  = 6'b010000;
    localparam logic [5:0] K_FIRE = 6'b001000;
    localparam logic [5:0] K_SURE = 6'b000100;
    localparam logic [5:0] K_CONF = 6'b000010;
    localparam logic [5:0] K_WAIT = 6'b000001;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    detonator_seq_ctrl_if bus();

    detonator_seq_ctrl #(
        .CODE_LEN(CL), .MAX_TRIES(MT), .TIMEOUT_CYC(TIMEOUT_CYC), .LOCK_CYC(LOCK_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] keys;
        logic [3:0] dig;
        logic [2:0] st;
        logic [2:0] cnt;
        logic [2:0] tries;
        logic       err;
        logic       fired;
        logic [2:0] lamps;
    } vec_t;

    vec_t vecs [24];

    // Reference model state
    int mState, mTries, mLast, mIdle, mLockCnt;
    bit mForce, mErr, mFired;
    int mCode[$];
    int mEntry[$];

    function automatic void modelReset();
        mState = 0; mTries = 0; mLast = 0; mIdle = 0; mLockCnt = 0;
        mForce = 0; mErr = 0; mFired = 0;
        mCode.delete(); mEntry.delete();
    endfunction

    function automatic void modelStep(input logic [5:0] k, input logic [3:0] d);
        bit s, r, f, su, c, w, match;
        int dv;
        dv = int'(d);
        w  = k[0];
        s  = k[5] & !w;
        r  = k[4] & !w;
        f  = k[3] & !w;
        su = k[2] & !w;
        c  = k[1] & !w & !(k[5] | k[4] | k[3] | k[2]);
        mErr = 0; mFired = 0;
        case (mState)
            0: if (s) begin mState = 1; mCode.delete(); end
            1: begin
                if (w) begin mState = 0; mCode.delete(); end
                else if (r) begin
                    if (mCode.size() == CL) begin mState = 2; mTries = MT; end
                    else mErr = 1;
                end else if (c) begin
                    if (dv <= 9 && mCode.size() < CL) begin mCode.push_back(dv); mLast = dv; end
                    else mErr = 1;
                end
            end
            2: begin
                if (w) begin mState = 0; mCode.delete(); end
                else if (f) begin mState = 3; mEntry.delete(); mIdle = 0; end
            end
            3: begin
                if (w) begin mState = 2; mEntry.delete(); end
                else if (su && mEntry.size() == CL) mState = 4;
                else if (c && dv <= 9 && mEntry.size() < CL) begin
                    mEntry.push_back(dv); mLast = dv; mIdle = 0;
                end else begin
                    if (su || c) mErr = 1;
                    if (TIMEOUT_ON) begin
                        mIdle++;
                        if (mIdle >= TIMEOUT_CYC) begin mState = 4; mForce = 1; end
                    end
                end
            end
            4: begin
                match = (mCode.size() == mEntry.size()) && !mForce;
                for (int i = 0; i < mCode.size() && i < mEntry.size(); i++)
                    if (mCode[i] != mEntry[i]) match = 0;
                mForce = 0;
                if (match) begin mState = 5; mFired = 1; end
                else begin
                    mErr = 1;
                    if (mTries > 0) mTries--;
                    if (mTries == 0) begin mState = 6; mLockCnt = 0; end
                    else mState = 2;
                end
            end
            6: begin
                mLockCnt++;
                if (mLockCnt >= LOCK_CYC) begin mState = 0; mCode.delete(); mEntry.delete(); end
            end
            default: ;
        endcase
    endfunction

    function automatic int expCnt();
        if (mState == 1) return mCode.size();
        if (mState == 3 || mState == 4 || mState == 5) return mEntry.size();
        return 0;
    endfunction

    function automatic logic [2:0] expLamps();
        return {mState == 0, mState == 2 || mState == 3, mState == 5 || mState == 6};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input int st, input int cnt, input int tries,
                            input bit e, input bit f, input logic [2:0] lamps);
        checkOutput({tag, "_state"}, 8'(bus.state), 8'(st));
        checkOutput({tag, "_cnt"},   8'(bus.digit_cnt), 8'(cnt));
        checkOutput({tag, "_tries"}, 8'(bus.tries_left), 8'(tries));
        checkOutput({tag, "_err"},   8'(bus.err), 8'(e));
        checkOutput({tag, "_fired"}, 8'(bus.fired), 8'(f));
        checkOutput({tag, "_lamps"}, 8'({bus.lt, bus.bt, bus.rt}), 8'(lamps));
    endtask

    task automatic checkModel();
        checkAll("rnd", mState, expCnt(), mTries, mErr, mFired, expLamps());
        checkOutput("rnd_last", 8'(bus.last_digit), 8'(mLast));
    endtask

    task automatic applyStimulus(input logic [5:0] k, input logic [3:0] d);
        bus.setup_p   = k[5];
        bus.ready_p   = k[4];
        bus.fire_p    = k[3];
        bus.sure_p    = k[2];
        bus.confirm_p = k[1];
        bus.wait_p    = k[0];
        bus.digit     = d;
        modelStep(k, d);
        @(posedge clk);
        #1;
        bus.setup_p = 0; bus.ready_p = 0; bus.fire_p = 0;
        bus.sure_p  = 0; bus.confirm_p = 0; bus.wait_p = 0;
    endtask

    task automatic doReset(input bit chk);
        rst = 1'b1;
        #2;
        if (chk) begin
            checkAll("rst_async", 0, 0, 0, 0, 0, 3'b100);
            checkOutput("rst_async_last", 8'(bus.last_digit), 8'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    task automatic armWith(input logic [3:0] d0, d1, d2, d3);
        applyStimulus(K_SET, 0);
        applyStimulus(K_CONF, d0); applyStimulus(K_CONF, d1);
        applyStimulus(K_CONF, d2); applyStimulus(K_CONF, d3);
        applyStimulus(K_RDY, 0);
    endtask

    task automatic enterAndSure(input logic [3:0] d0, d1, d2, d3);
        applyStimulus(K_FIRE, 0);
        applyStimulus(K_CONF, d0); applyStimulus(K_CONF, d1);
        applyStimulus(K_CONF, d2); applyStimulus(K_CONF, d3);
        applyStimulus(K_SURE, 0);
    endtask

    task automatic threeWrong();
        for (int k = 1; k <= 3; k++) begin
            enterAndSure(1, 2, 3, 5);
            checkAll("wrong_check", 4, 4, 4 - k, 0, 0, 3'b000);
            applyStimulus(K_NONE, 0);
            checkAll("wrong_result", (k == 3) ? 6 : 2, 0, 3 - k, 1, 0,
                     (k == 3) ? 3'b001 : 3'b010);
        end
    endtask

    initial begin
        logic [5:0] k;
        logic [3:0] d;
        int dsel;
        total = 0; bad = 0;
        rst = 1'b1;
        bus.setup_p = 0; bus.ready_p = 0; bus.fire_p = 0;
        bus.sure_p  = 0; bus.confirm_p = 0; bus.wait_p = 0; bus.digit = 0;
        modelReset();

        vecs[0]  = '{K_SET,  4'd0,  3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 3'b000};
        vecs[1]  = '{K_CONF, 4'd1,  3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 3'b000};
        vecs[2]  = '{K_CONF, 4'd12, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0, 3'b000};
        vecs[3]  = '{K_CONF, 4'd2,  3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 3'b000};
        vecs[4]  = '{K_RDY,  4'd0,  3'd1, 3'd2, 3'd0, 1'b1, 1'b0, 3'b000};
        vecs[5]  = '{K_CONF, 4'd3,  3'd1, 3'd3, 3'd0, 1'b0, 1'b0, 3'b000};
        vecs[6]  = '{K_CONF, 4'd4,  3'd1, 3'd4, 3'd0, 1'b0, 1'b0, 3'b000};
        vecs[7]  = '{K_CONF, 4'd5,  3'd1, 3'd4, 3'd0, 1'b1, 1'b0, 3'b000};
        vecs[8]  = '{K_RDY,  4'd0,  3'd2, 3'd0, 3'd3, 1'b0, 1'b0, 3'b010};
        vecs[9]  = '{K_FIRE, 4'd0,  3'd3, 3'd0, 3'd3, 1'b0, 1'b0, 3'b010};
        vecs[10] = '{K_CONF, 4'd1,  3'd3, 3'd1, 3'd3, 1'b0, 1'b0, 3'b010};
        vecs[11] = '{K_CONF, 4'd2,  3'd3, 3'd2, 3'd3, 1'b0, 1'b0, 3'b010};
        vecs[12] = '{K_SURE, 4'd0,  3'd3, 3'd2, 3'd3, 1'b1, 1'b0, 3'b010};
        vecs[13] = '{K_CONF, 4'd3,  3'd3, 3'd3, 3'd3, 1'b0, 1'b0, 3'b010};
        vecs[14] = '{K_CONF, 4'd4,  3'd3, 3'd4, 3'd3, 1'b0, 1'b0, 3'b010};
        vecs[15] = '{K_SURE | K_WAIT, 4'd0, 3'd2, 3'd0, 3'd3, 1'b0, 1'b0, 3'b010};
        vecs[16] = '{K_FIRE, 4'd0,  3'd3, 3'd0, 3'd3, 1'b0, 1'b0, 3'b010};
        vecs[17] = '{K_CONF, 4'd1,  3'd3, 3'd1, 3'd3, 1'b0, 1'b0, 3'b010};
        vecs[18] = '{K_CONF, 4'd2,  3'd3, 3'd2, 3'd3, 1'b0, 1'b0, 3'b010};
        vecs[19] = '{K_CONF, 4'd3,  3'd3, 3'd3, 3'd3, 1'b0, 1'b0, 3'b010};
        vecs[20] = '{K_CONF, 4'd4,  3'd3, 3'd4, 3'd3, 1'b0, 1'b0, 3'b010};
        vecs[21] = '{K_SURE, 4'd0,  3'd4, 3'd4, 3'd3, 1'b0, 1'b0, 3'b000};
        vecs[22] = '{K_NONE, 4'd0,  3'd5, 3'd4, 3'd3, 1'b0, 1'b1, 3'b001};
        vecs[23] = '{K_SET,  4'd0,  3'd5, 3'd4, 3'd3, 1'b0, 1'b0, 3'b001};

        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 0, 0, 0, 0, 0, 3'b100);
        checkOutput("reset_last", 8'(bus.last_digit), 8'd0);
        rst = 1'b0;

        $display("[TB] directed table");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].keys, vecs[i].dig);
            checkAll($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].cnt),
                     int'(vecs[i].tries), vecs[i].err, vecs[i].fired, vecs[i].lamps);
        end
        checkOutput("vec_last", 8'(bus.last_digit), 8'd4);

        $display("[TB] lockout sequence");
        doReset(1'b1);
        armWith(1, 2, 3, 4);
        checkAll("armed", 2, 0, 3, 0, 0, 3'b010);
        threeWrong();
        repeat (LOCK_CYC - 1) applyStimulus(K_NONE, 0);
        checkAll("lock_hold", 6, 0, 0, 0, 0, 3'b001);
        applyStimulus(K_NONE, 0);
        checkAll("lock_release", 0, 0, 0, 0, 0, 3'b100);
        applyStimulus(K_FIRE, 0);
        checkAll("idle_fire", 0, 0, 0, 0, 0, 3'b100);
        applyStimulus(K_SET, 0);
        applyStimulus(K_RDY, 0);
        checkAll("empty_ready", 1, 0, 0, 1, 0, 3'b000);

        $display("[TB] reset during lock");
        doReset(1'b0);
        armWith(1, 2, 3, 4);
        threeWrong();
        repeat (5) applyStimulus(K_NONE, 0);
        doReset(1'b1);
        applyStimulus(K_FIRE, 0);
        checkAll("post_lock_rst", 0, 0, 0, 0, 0, 3'b100);

        $display("[TB] reset during entry");
        armWith(1, 2, 3, 4);
        applyStimulus(K_FIRE, 0);
        applyStimulus(K_CONF, 1);
        applyStimulus(K_CONF, 2);
        checkAll("entry_mid", 3, 2, 3, 0, 0, 3'b010);
        doReset(1'b1);
        applyStimulus(K_FIRE, 0);
        checkAll("post_entry_rst", 0, 0, 0, 0, 0, 3'b100);

`ifdef DETONATOR_ENTRY_TIMEOUT_EN
        $display("[TB] entry timeout");
        doReset(1'b0);
        armWith(1, 2, 3, 4);
        applyStimulus(K_FIRE, 0);
        applyStimulus(K_CONF, 1);
        repeat (TIMEOUT_CYC - 1) applyStimulus(K_NONE, 0);
        checkAll("to_wait", 3, 1, 3, 0, 0, 3'b010);
        applyStimulus(K_NONE, 0);
        checkAll("to_check", 4, 1, 3, 0, 0, 3'b000);
        applyStimulus(K_NONE, 0);
        checkAll("to_result", 2, 0, 2, 1, 0, 3'b010);
`endif

        $display("[TB] random run");
        doReset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            k[5] = ($urandom_range(0, 99) < 6);
            k[4] = ($urandom_range(0, 99) < 8);
            k[3] = ($urandom_range(0, 99) < 8);
            k[2] = ($urandom_range(0, 99) < 8);
            k[1] = ($urandom_range(0, 99) < 35);
            k[0] = ($urandom_range(0, 99) < 3);
            dsel = $urandom_range(0, 9);
            d = (dsel == 0) ? 4'd12 : 4'(1 + (dsel % 2));
            applyStimulus(k, d);
            checkModel();
            if ((mState == 5 && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0)
                doReset(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
